// File: rtl/fpnew_pkg.sv
// Shared FPU types: the IEEE 754 exception flag vector used by all operation units.
package fpnew_pkg;

  typedef struct packed {
    logic NV;  // invalid operation
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

endpackage

// File: rtl/fpnew_pipe_out_spill.sv
// Two-entry spill buffer: in-order FIFO whose ready_o depends only on its own
// occupancy, which cuts the combinational ready path from downstream to upstream.
module fpnew_pipe_out_spill #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic busy_o
);

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q;
  T           mem_q [2];
  logic       push, pop;

  assign ready_o = (count_q != 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign busy_o  = valid_o;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload registers are only cleared by reset; flush just drops the occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fpnew_pipe_out.sv
// Output pipeline of an FPU operation unit: NumPipeRegs valid/ready register stages,
// optionally followed by a two-entry spill buffer when FPNEW_PIPE_OUT_SPILL_EN is defined.
module fpnew_pipe_out
  import fpnew_pkg::*;
#(
  parameter int unsigned Width       = 32,
  parameter int unsigned NumPipeRegs = 0,
  parameter type         TagType     = logic,
  parameter type         AuxType     = logic
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] result_i,
  input  status_t          status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  input  AuxType           aux_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             flush_i,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output AuxType           aux_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o
);

  // Handshake: a beat transfers on a cycle where valid and ready are both high;
  // valid never depends on ready, and payload holds while valid && !ready.
  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext;
    TagType           tag;
    AuxType           aux;
  } payload_t;

  payload_t in_payload, tail_data, out_data;
  logic     tail_valid, tail_ready;
  logic     pipe_busy, spill_busy;

  always_comb begin
    in_payload        = '0;
    in_payload.result = result_i;
    in_payload.status = status_i;
    in_payload.ext    = extension_bit_i;
    in_payload.tag    = tag_i;
    in_payload.aux    = aux_i;
  end

  if (NumPipeRegs == 0) begin : g_no_regs
    assign tail_valid = in_valid_i;
    assign tail_data  = in_payload;
    assign in_ready_o = tail_ready;
    assign pipe_busy  = in_valid_i;
  end else begin : g_regs
    logic [NumPipeRegs:0]   vld, rdy;
    payload_t               dat     [NumPipeRegs+1];
    logic [NumPipeRegs-1:0] valid_q;
    payload_t               data_q  [NumPipeRegs];

    // Index 0 is the upstream interface, index i+1 is the output of register stage i.
    always_comb begin
      vld    = {valid_q, in_valid_i};
      dat[0] = in_payload;
      for (int i = 0; i < NumPipeRegs; i++) dat[i+1] = data_q[i];
      rdy              = '0;
      rdy[NumPipeRegs] = tail_ready;
      for (int i = NumPipeRegs - 1; i >= 0; i--) rdy[i] = rdy[i+1] | ~vld[i+1];
    end

    always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumPipeRegs; i++) begin
        if (rst_i) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
        end else begin
          if (flush_i)     valid_q[i] <= 1'b0;
          else if (rdy[i]) valid_q[i] <= vld[i];
          // Data enable ignores flush: a flushed stage's stale data is simply invalid.
          if (rdy[i] && vld[i]) data_q[i] <= dat[i];
        end
      end
    end

    assign tail_valid = vld[NumPipeRegs];
    assign tail_data  = dat[NumPipeRegs];
    assign in_ready_o = rdy[0];
    assign pipe_busy  = |vld;
  end

`ifdef FPNEW_PIPE_OUT_SPILL_EN
  fpnew_pipe_out_spill #(
    .T(payload_t)
  ) i_spill (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (tail_valid),
    .ready_o (tail_ready),
    .data_i  (tail_data),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (out_data),
    .busy_o  (spill_busy)
  );
`else
  assign tail_ready  = out_ready_i;
  assign out_valid_o = tail_valid;
  assign out_data    = tail_data;
  assign spill_busy  = 1'b0;
`endif

  assign busy_o          = pipe_busy | spill_busy;
  assign result_o        = out_data.result;
  assign status_o        = out_data.status;
  assign extension_bit_o = out_data.ext;
  assign tag_o           = out_data.tag;
  assign aux_o           = out_data.aux;

endmodule

// File: tb/tb_fpnew_pipe_out.sv
// Bench for fpnew_pipe_out: a 2-stage instance with a queue-based reference model
// and a 3-stage instance for fill/backpressure checks; adapts to FPNEW_PIPE_OUT_SPILL_EN.
module tb_fpnew_pipe_out;
  import fpnew_pkg::*;

  localparam int W = 32;
`ifdef FPNEW_PIPE_OUT_SPILL_EN
  localparam int SPILL = 1;
`else
  localparam int SPILL = 0;
`endif
  localparam int LAT2 = 2 + SPILL;
  localparam int CAP3 = 3 + 2 * SPILL;

  typedef logic [3:0] tag_t;
  typedef logic [7:0] aux_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-stage instance
  logic [W-1:0] res_i, res_o;
  status_t      st_i, st_o;
  logic         ext_i, ext_o;
  tag_t         tag_i, tag_o;
  aux_t         aux_i, aux_o;
  logic         in_valid, in_ready, flush, out_valid, out_ready, busy;

  // 3-stage instance
  logic [W-1:0] res3_i, res3_o;
  status_t      st3_o;
  logic         ext3_o;
  tag_t         tag3_i, tag3_o;
  aux_t         aux3_o;
  logic         in_valid3, in_ready3, out_valid3, out_ready3, busy3;

  fpnew_pipe_out #(
    .Width(W), .NumPipeRegs(2), .TagType(tag_t), .AuxType(aux_t)
  ) dut2 (
    .clk_i(clk), .rst_i(rst),
    .result_i(res_i), .status_i(st_i), .extension_bit_i(ext_i), .tag_i(tag_i), .aux_i(aux_i),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush),
    .result_o(res_o), .status_o(st_o), .extension_bit_o(ext_o), .tag_o(tag_o), .aux_o(aux_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy)
  );

  fpnew_pipe_out #(
    .Width(W), .NumPipeRegs(3), .TagType(tag_t), .AuxType(aux_t)
  ) dut3 (
    .clk_i(clk), .rst_i(rst),
    .result_i(res3_i), .status_i(status_t'(5'b0)), .extension_bit_i(1'b0), .tag_i(tag3_i),
    .aux_i(aux_t'(8'h0)),
    .in_valid_i(in_valid3), .in_ready_o(in_ready3), .flush_i(1'b0),
    .result_o(res3_o), .status_o(st3_o), .extension_bit_o(ext3_o), .tag_o(tag3_o), .aux_o(aux3_o),
    .out_valid_o(out_valid3), .out_ready_i(out_ready3), .busy_o(busy3)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [49:0] pack(logic [31:0] r, status_t s, logic e, tag_t t, aux_t a);
    return {r, s, e, t, a};
  endfunction

  // ---------------- scoreboard (2-stage instance) ----------------
  // Model: every accepted item is delivered once, in order; flush/reset drop all in flight.
  logic [49:0] exp_q[$];
  logic [49:0] prev_word;
  logic        hold_prev = 1'b0;

  always @(negedge clk) begin
    logic [49:0] out_word, exp_word;
    out_word = pack(res_o, st_o, ext_o, tag_o, aux_o);
    if (hold_prev) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_data", 64'(out_word), 64'(prev_word));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check_eq("sb_data", 64'(out_word), 64'(exp_word));
      end
    end
    hold_prev = (out_valid === 1'b1) && (out_ready === 1'b0) && (flush === 1'b0) && (rst === 1'b0);
    prev_word = out_word;
    if (rst === 1'b1 || flush === 1'b1) exp_q.delete();
    else if (in_valid === 1'b1 && in_ready === 1'b1)
      exp_q.push_back(pack(res_i, st_i, ext_i, tag_i, aux_i));
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic [31:0] r, input logic [4:0] s, input logic e,
                        input logic [3:0] t, input logic v);
    res_i = r; st_i = s; ext_i = e; tag_i = t; aux_i = r[7:0]; in_valid = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, found, acc, cyc, n;
    logic r0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive2(32'h0, 5'h0, 1'b0, 4'h0, 1'b0);
    res3_i = '0; tag3_i = '0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    repeat (2) next_cycle();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(res_o), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_valid3", 64'(out_valid3), 64'd0);
    rst = 1'b0;

    // Single item latency
    next_cycle();
    out_ready = 1'b1;
    drive2(32'h3F80_0000, 5'h0, 1'b0, 4'd5, 1'b1);
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        next_cycle();
        in_valid = 1'b0;
      end
      #1;
      if (k == 0) check_eq("lat_in_ready", 64'(in_ready), 64'd1);
      if (out_valid && lat < 0) begin
        lat = k;
        check_eq("lat_result", 64'(res_o), 64'h3F80_0000);
        check_eq("lat_tag", 64'(tag_o), 64'd5);
      end
    end
    check_eq("latency", 64'(lat), 64'(LAT2));

    // Status and extension bit travel with their own result
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      drive2(32'h4000_0000 + j, (j == 1) ? 5'b10001 : 5'b00000, (j == 1), 4'(j), 1'b1);
    end
    next_cycle();
    in_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid && res_o == 32'h4000_0001) begin
        found++;
        check_eq("flags_status", 64'(st_o), 64'b10001);
        check_eq("flags_ext", 64'(ext_o), 64'd1);
      end
      next_cycle();
    end
    check_eq("flags_found", 64'(found), 64'd1);

    // Flush with two in flight and a simultaneous input
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      next_cycle();
      drive2(32'h5000_0000 + j, 5'h0, 1'b0, 4'(j), 1'b1);
    end
    next_cycle();
    drive2(32'h5000_0002, 5'h0, 1'b0, 4'd2, 1'b1);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      check_eq("flush_gone", 64'(out_valid), 64'd0);
    end

    // Reset with two in flight
    out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      next_cycle();
      drive2(32'h6000_0000 + j, 5'h3, 1'b1, 4'(j), 1'b1);
    end
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("mrst_valid", 64'(out_valid), 64'd0);
    check_eq("mrst_result", 64'(res_o), 64'd0);
    check_eq("mrst_busy_idle", 64'(busy), 64'd0);
    in_valid = 1'b1;
    #1;
    check_eq("mrst_busy_in", 64'(busy), 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      check_eq("mrst_no_stale", 64'(out_valid), 64'd0);
    end

    // Fill the 3-stage instance under backpressure, then pop once
    acc = 0;
    for (int w = 0; w < CAP3; w++) begin
      res3_i = 100 + acc; tag3_i = 4'(acc); in_valid3 = 1'b1;
      #1;
      check_eq("fill_ready", 64'(in_ready3), 64'd1);
      if (in_ready3) acc++;
      next_cycle();
    end
    res3_i = 100 + acc; tag3_i = 4'(acc);
    #1;
    check_eq("full_ready", 64'(in_ready3), 64'd0);
    check_eq("full_accept", 64'(acc), 64'(CAP3));
    out_ready3 = 1'b1;
    #1;
    check_eq("pop_head", 64'(res3_o), 64'd100);
`ifndef FPNEW_PIPE_OUT_SPILL_EN
    check_eq("pop_ready_same", 64'(in_ready3), 64'd1);
`endif
    if (in_ready3) acc++;
    next_cycle();
    out_ready3 = 1'b0;
`ifdef FPNEW_PIPE_OUT_SPILL_EN
    #1;
    check_eq("pop_ready_next", 64'(in_ready3), 64'd1);
    if (in_ready3) acc++;
    next_cycle();
`endif
    in_valid3 = 1'b0;
    check_eq("accept_total", 64'(acc), 64'(CAP3 + 1));
    out_ready3 = 1'b1;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (out_valid3) begin
        check_eq("drain3_order", 64'(res3_o), 64'(100 + n));
        check_eq("drain3_tag", 64'(tag3_o), 64'(4'(n)));
        n++;
      end
      next_cycle();
    end
    check_eq("drain3_count", 64'(n), 64'(CAP3 + 1));

    // Random traffic with out_ready toggling 1,0,1,0
    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 1000) begin
      next_cycle();
      cyc++;
      out_ready = (cyc % 2 == 1);
      drive2($urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      #1;
`ifdef FPNEW_PIPE_OUT_SPILL_EN
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      check_eq("ready_indep", 64'(in_ready), 64'(r0));
      out_ready = ~out_ready;
      #1;
`else
      r0 = 1'b0;
`endif
      if (in_valid && in_ready) acc++;
    end
    check_eq("rand_accepted", 64'(acc), 64'd100);
    next_cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) next_cycle();
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("end_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fpnew_pipe_out.md
FPNEW_PIPE_OUT -- requirements
Module: fpnew_pipe_out

Interface
REQ-001 SHALL have parameter Width, default 32: result width in bits.
REQ-002 SHALL have parameter NumPipeRegs, default 0: number of output register stages.
REQ-003 SHALL have parameter TagType, default logic: opaque tag type.
REQ-004 SHALL have parameter AuxType, default logic: opaque aux type.
REQ-005 SHALL have port clk_i  in  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port result_i  in  Width  result from the operation unit.
REQ-008 SHALL have port status_i  in  fpnew_pkg::status_t (5)  exception flags NV,DZ,OF,UF,NX.
REQ-009 SHALL have port extension_bit_i  in  1  NaN-box/sign-extension bit.
REQ-010 SHALL have ports tag_i (TagType) and aux_i (AuxType), both inputs, carried alongside the result.
REQ-011 SHALL have ports in_valid_i in 1, in_ready_o out 1, flush_i in 1: upstream handshake and flush.
REQ-012 SHALL have ports result_o, status_o, extension_bit_o, tag_o and aux_o as outputs mirroring the inputs.
REQ-013 SHALL have ports out_valid_o out 1, out_ready_i in 1, busy_o out 1.

Function
REQ-014 SHALL, with NumPipeRegs=0 and no spill, connect all inputs to outputs combinationally, with in_ready_o=out_ready_i.
REQ-015 SHALL give stage i a ready of ready[i+1] OR NOT valid[i+1]; a bubble is popped even while out_ready_i=0.
REQ-016 SHALL load valid[i+1] from valid[i] when ready[i]=1.
REQ-017 SHALL load the data registers of stage i+1 only when ready[i] AND valid[i] (clock-gate friendly enable).
REQ-018 SHALL deliver a result NumPipeRegs cycles after acceptance when there is no backpressure; order is preserved; nothing is dropped or duplicated.
REQ-019 SHALL make a transfer happen only on a cycle where valid AND ready are both 1; out_valid_o plus the data SHALL hold stable while out_ready_i=0.
REQ-020 SHALL, on flush_i=1, clear all valid bits at the next edge; flush wins over a simultaneous in_valid_i, so that item is discarded; data registers are not cleared.
REQ-021 SHALL set busy_o to the OR of in_valid_i and every stage valid (including spill entries).
REQ-022 SHALL, with every stage full and out_ready_i=0, drive in_ready_o=0; a single output pop SHALL let one new item enter that same cycle.

Reset
REQ-023 SHALL, when rst_i=1 at an edge, clear every valid bit, and reset result, status, extension bit, tag and aux registers to '0.
REQ-024 SHALL, during and after reset, output out_valid_o=0 and busy_o=in_valid_i; reset mid-transfer discards all in-flight items.

Configuration
REQ-025 SHALL, with macro FPNEW_PIPE_OUT_SPILL_EN defined, append a two-entry spill buffer after the last stage; this adds 1 cycle latency and makes ready[NumPipeRegs] depend only on spill state (no combinational out_ready_i to in_ready_o path).
REQ-026 SHALL, with the macro defined, fill the spill entries in order and keep output from the oldest entry; full throughput is sustained; flush and reset empty both entries.
REQ-027 SHALL, without the macro, connect ready[NumPipeRegs]=out_ready_i, add no spill logic, and add no extra latency.

Structure
REQ-028 SHALL take status_t, with fields NV,DZ,OF,UF,NX, from fpnew_pkg; no new package types are needed.
REQ-029 SHALL implement the spill buffer as sub-module fpnew_pipe_out_spill, parameterised by the payload type.

Verification
REQ-030 SHALL cover: NumPipeRegs=2, out_ready_i=1, result_i=32'h3F80_0000 tag=5 accepted cycle 0 -> out_valid_o=1, result_o=32'h3F80_0000, tag_o=5 at cycle 2.
REQ-031 SHALL cover: NumPipeRegs=3, out_ready_i=0, 4 items pushed back-to-back -> in_ready_o=0 after 3 accepted; one pop lets item 4 enter that cycle.
REQ-032 SHALL cover: NumPipeRegs=2, 2 items in flight plus flush_i=1 with in_valid_i=1 -> next cycle all valid=0, busy_o=0 if in_valid_i=0, and the flushed items never appear.
REQ-033 SHALL cover: status_i=5'b10001, extension_bit_i=1 -> status_o=5'b10001 and extension_bit_o=1 delivered together with their own result.
REQ-034 SHALL cover: rst_i=1 asserted for 1 cycle with 2 items in flight -> out_valid_o=0 and result_o=0 the next cycle, and no stale output afterwards.
REQ-035 SHALL cover: FPNEW_PIPE_OUT_SPILL_EN defined, out_ready_i toggling 1010 over 100 random items -> same order, no loss, and in_ready_o independent of out_ready_i within the cycle.
